// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and default sizing for the shared-register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shared_reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_MAX_HOLD = 16;

    // Index width for n items; never zero so single-bit vectors stay legal
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter: requests, strobes, data, grant/status.
// Latency: n/a (wiring only).
// Backpressure: requesters wait for grant; there is no other flow control.
interface shared_reg_arbiter_if
    import shared_reg_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) ();
    localparam int IW = idx_w(N);

    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [W-1:0]   q;
    logic [IW-1:0]  owner;
    logic           busy;
    logic           timeout;

    modport master (output req, we, wdata, input grant, q, owner, busy, timeout);
    modport slave  (input req, we, wdata, output grant, q, owner, busy, timeout);

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping to 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any=0 when no request is pending.
module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);
    logic [N-1:0] rot;
    logic [IW:0]  sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then map back to an absolute index
    always_comb begin
        rot    = N'({req, req} >> ptr);
        winner = '0;
        any    = 1'b0;
        sum    = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IW+1)'(i);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                winner = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbiter + write sequencer for one shared register; optional forced release via SHREG_ARB_TIMEOUT_EN.
// Latency: grant 1 edge after req in IDLE, write visible 1 edge after strobe, one idle cycle between owners.
// Backpressure: non-owners simply wait; their strobes are dropped until they hold grant.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_reg_arbiter_if.slave   bus
);
    localparam int IW = idx_w(N);

    if (N < 2 || W < 1 || MAX_HOLD < 1) begin : g_param_chk
        $error("shared_reg_arbiter: needs N >= 2, W >= 1, MAX_HOLD >= 1");
    end

    state_t        state, state_nxt;
    logic [N-1:0]  grant_r, grant_nxt;
    logic [IW-1:0] owner_r, owner_nxt;
    logic [IW-1:0] ptr_r, ptr_nxt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] after_owner;
    logic          owner_req;
    logic          owner_wr;
    logic [W-1:0]  q_r;

`ifdef SHREG_ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CW-1:0] hold_r, hold_nxt;
    logic          to_r, to_nxt;
`endif

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_r),
        .winner (pick_idx),
        .any    (pick_any)
    );

    assign owner_req   = bus.req[owner_r];
    assign owner_wr    = (state == GRANT) && owner_req && bus.we[owner_r];
    assign after_owner = (owner_r == IW'(N-1)) ? '0 : owner_r + 1'b1;

    // Next-state logic: grant from IDLE, release to IDLE on request drop (or hold limit)
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_r;
        owner_nxt = owner_r;
        ptr_nxt   = ptr_r;
`ifdef SHREG_ARB_TIMEOUT_EN
        hold_nxt  = hold_r;
        to_nxt    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
`ifdef SHREG_ARB_TIMEOUT_EN
                hold_nxt = '0;
`endif
                if (pick_any) begin
                    state_nxt = GRANT;
                    grant_nxt = N'(1) << pick_idx;
                    owner_nxt = pick_idx;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = after_owner;
`ifdef SHREG_ARB_TIMEOUT_EN
                    hold_nxt  = '0;
`endif
                end else begin
`ifdef SHREG_ARB_TIMEOUT_EN
                    // Owner has now held grant for MAX_HOLD cycles: force it off
                    if (hold_r == CW'(MAX_HOLD-1)) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        ptr_nxt   = after_owner;
                        hold_nxt  = '0;
                        to_nxt    = 1'b1;
                    end else begin
                        hold_nxt  = hold_r + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Arbitration state registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_r <= '0;
            owner_r <= '0;
            ptr_r   <= '0;
`ifdef SHREG_ARB_TIMEOUT_EN
            hold_r  <= '0;
            to_r    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            grant_r <= grant_nxt;
            owner_r <= owner_nxt;
            ptr_r   <= ptr_nxt;
`ifdef SHREG_ARB_TIMEOUT_EN
            hold_r  <= hold_nxt;
            to_r    <= to_nxt;
`endif
        end
    end

    // Shared data register: loads only from the current owner's strobe, including on a forced-release edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (owner_wr) begin
            q_r <= bus.wdata[int'(owner_r)*W +: W];
        end
    end

    assign bus.grant = grant_r;
    assign bus.q     = q_r;
    assign bus.owner = owner_r;
    assign bus.busy  = (state == GRANT);
`ifdef SHREG_ARB_TIMEOUT_EN
    assign bus.timeout = to_r;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N=4, W=8, MAX_HOLD=4).
// Latency: expectations are queued per driven cycle and checked 1ns after the next rising edge.
// Backpressure: n/a.
module tb_shared_reg_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.N(4), .W(8)) bus ();

    shared_reg_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] q;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".grant"},   32'(bus.grant),   32'(e.grant));
        chk({tag, ".q"},       32'(bus.q),       32'(e.q));
        chk({tag, ".owner"},   32'(bus.owner),   32'(e.owner));
        chk({tag, ".busy"},    32'(bus.busy),    32'(e.busy));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(e.timeout));
    endtask

    // Apply one cycle of stimulus, queue what the outputs must be after the next edge, then compare
    task automatic drive(input string tag, input logic [3:0] r, input logic [3:0] w,
                         input logic [31:0] d, input logic [3:0] eg, input logic [7:0] eq,
                         input logic [1:0] eo, input logic eb, input logic et);
        exp_t e;
        bus.req   = r;
        bus.we    = w;
        bus.wdata = d;
        sb.push_back('{grant: eg, q: eq, owner: eo, busy: eb, timeout: et});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(tag, e);
    endtask

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.wdata = '0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check_outputs("reset_init", '{grant: 4'h0, q: 8'h00, owner: 2'd0, busy: 1'b0, timeout: 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single owner; non-owner strobe ignored; strobe with req low ignored
        drive("single_gnt",   4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b0);
        drive("single_wr",    4'b0001, 4'b0101, 32'h00FF_003C, 4'b0001, 8'h3C, 2'd0, 1'b1, 1'b0);
        drive("nonowner_wr",  4'b0001, 4'b0100, 32'h00FF_0000, 4'b0001, 8'h3C, 2'd0, 1'b1, 1'b0);
        drive("single_rel",   4'b0000, 4'b0001, 32'h0000_0011, 4'b0000, 8'h3C, 2'd0, 1'b0, 1'b0);

        // Owner 1 writes A5, then reset lands between edges
        drive("own1_gnt",     4'b0010, 4'b0000, 32'h0000_0000, 4'b0010, 8'h3C, 2'd1, 1'b1, 1'b0);
        drive("own1_wr",      4'b0010, 4'b0010, 32'h0000_A500, 4'b0010, 8'hA5, 2'd1, 1'b1, 1'b0);
        bus.we = '0;
        #2 rst = 1'b1;
        #1;
        check_outputs("reset_mid", '{grant: 4'h0, q: 8'h00, owner: 2'd0, busy: 1'b0, timeout: 1'b0});
        bus.req = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Strict rotation with all requesting; each owner drops after two granted cycles
        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            oh = 4'(1 << k);
            drive("rot_gnt",  4'hF,       4'h0, 32'h0, oh,      8'h00, 2'(k), 1'b1, 1'b0);
            drive("rot_hold", 4'hF,       4'h0, 32'h0, oh,      8'h00, 2'(k), 1'b1, 1'b0);
            drive("rot_rel",  4'hF & ~oh, 4'h0, 32'h0, 4'b0000, 8'h00, 2'(k), 1'b0, 1'b0);
        end
        drive("rot_wrap",     4'hF,    4'h0, 32'h0, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b0);
        drive("rot_wrap_rel", 4'b1110, 4'h0, 32'h0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);

        // Wrap from ptr=3 and priority from ptr=1 with req=0101
        drive("pre_own2",     4'b0100, 4'h0, 32'h0, 4'b0100, 8'h00, 2'd2, 1'b1, 1'b0);
        drive("pre_own2_rel", 4'b0000, 4'h0, 32'h0, 4'b0000, 8'h00, 2'd2, 1'b0, 1'b0);
        drive("wrap_ptr3",    4'b0101, 4'h0, 32'h0, 4'b0001, 8'h00, 2'd0, 1'b1, 1'b0);
        drive("wrap_rel",     4'b0000, 4'h0, 32'h0, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        drive("prio_ptr1",    4'b0101, 4'h0, 32'h0, 4'b0100, 8'h00, 2'd2, 1'b1, 1'b0);
        drive("prio_wr",      4'b0101, 4'b0100, 32'h005A_0000, 4'b0100, 8'h5A, 2'd2, 1'b1, 1'b0);
        drive("prio_rel",     4'b0000, 4'h0, 32'h0, 4'b0000, 8'h5A, 2'd2, 1'b0, 1'b0);

        // Move ptr to 1 so owner 1 wins against pending requester 3
        drive("pre_to_gnt",   4'b0001, 4'h0, 32'h0, 4'b0001, 8'h5A, 2'd0, 1'b1, 1'b0);
        drive("pre_to_rel",   4'b0000, 4'h0, 32'h0, 4'b0000, 8'h5A, 2'd0, 1'b0, 1'b0);
        drive("hold_gnt",     4'b1010, 4'h0, 32'h0, 4'b0010, 8'h5A, 2'd1, 1'b1, 1'b0);
`ifdef SHREG_ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            drive("hold_cyc", 4'b1010, 4'h0, 32'h0, 4'b0010, 8'h5A, 2'd1, 1'b1, 1'b0);
        end
        drive("force_rel",    4'b1010, 4'b0010, 32'h0000_C300, 4'b0000, 8'hC3, 2'd1, 1'b0, 1'b1);
        drive("after_to",     4'b1010, 4'h0, 32'h0, 4'b1000, 8'hC3, 2'd3, 1'b1, 1'b0);
        drive("after_to_rel", 4'b0000, 4'h0, 32'h0, 4'b0000, 8'hC3, 2'd3, 1'b0, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            drive("hold_cyc", 4'b1010, 4'h0, 32'h0, 4'b0010, 8'h5A, 2'd1, 1'b1, 1'b0);
        end
        drive("hold_wr",      4'b1010, 4'b0010, 32'h0000_C300, 4'b0010, 8'hC3, 2'd1, 1'b1, 1'b0);
        drive("hold_rel",     4'b1000, 4'h0, 32'h0, 4'b0000, 8'hC3, 2'd1, 1'b0, 1'b0);
        drive("next_gnt",     4'b1000, 4'h0, 32'h0, 4'b1000, 8'hC3, 2'd3, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and write sequencer for a single W-bit shared data register built from asynchronously reset D flip-flops. Up to N requesters compete for write ownership. The block grants one owner at a time, loads the owner's data into the register on its write strobes, and releases ownership on request drop. It sits between the requesting control blocks and the shared register in the datapath.

## Interface
Parameters:
- N, 4: number of requesters (≥2).
- W, 8: shared register width.
- MAX_HOLD, 16: maximum consecutive granted cycles; used only when SHREG_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  per-requester ownership request, level.
- we  in  N  per-requester write strobe.
- wdata  in  N*W  flattened write data; slice i is bits [i*W +: W].
- grant  out  N  one-hot registered grant, or all zero.
- q  out  W  shared register contents.
- owner  out  $clog2(N)  index of current/last owner.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse on forced release (0 without the macro).

## Operation
- Reset (rst=1, any time, overrides all else): the following are cleared immediately:
  - q=0, grant=0, owner=0, busy=0, timeout=0.
  - Round-robin pointer ptr=0, hold counter=0, state=IDLE.
- IDLE:
  - If req≠0, the winner is the first set req bit searching upward from ptr with wrap (ptr, ptr+1, …, N-1, 0, …).
  - Next edge: state=GRANT, grant=onehot(winner), owner=winner, busy=1.
  - If req=0, stay in IDLE.
- GRANT, owner g:
  - If req[g]=1 and we[g]=1 at an edge, q <= wdata slice g.
  - we from non-owners is ignored. we[g] with req[g]=0 is ignored.
  - If req[g]=0 at an edge: grant=0, busy=0, ptr=(g+1) mod N, state=IDLE.
- The IDLE turnaround is mandatory: there is no direct grant handoff, and at least one all-zero grant cycle separates owners.
- owner holds its last value through IDLE.
- q changes only on an owner write or reset.

## Timing
- req sampled high at edge k (IDLE) → grant high after edge k; first possible write takes effect at edge k+1.
- Write latency: the owner's we/wdata sampled at edge e → q valid after edge e.
- Release: req[g] sampled low at edge r → grant=0 after edge r. The next owner is granted after edge r+1.
- Minimum cycles between two owners' grants: 1 idle cycle.
- Simultaneous requests in IDLE: exactly one grant, chosen by ptr order. With all N requesting continuously, each owner is served in strict rotation.
- Requester re-asserts req immediately after release: it is eligible, but at lowest priority.
- Reset mid-write: q=0 regardless of the in-flight write.

## Configuration
- SHREG_ARB_TIMEOUT_EN defined:
  - Hold counter increments each GRANT cycle.
  - When the owner has been granted MAX_HOLD cycles and req[g] is still 1, the next edge forces release: grant=0, state=IDLE, ptr=(g+1) mod N, timeout=1 for one cycle.
  - A write strobed on the forcing edge is still performed.
  - Counter clears on entering IDLE.
- Macro not defined: no counter; timeout is tied to 0; ownership lasts until req[g] drops.

## Structure
- Package shared_reg_arb_pkg holds:
  - state enum {IDLE, GRANT}.
  - Default N, W and MAX_HOLD constants.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req, ptr.
  - Outputs: winner index, any-valid.
- The data register, FSM, pointer and counter live in the top module.

## Test plan
- Reset: rst pulsed mid-simulation with q=8'hA5 and grant=0010 → q=0, grant=0, owner=0, busy=0 immediately, before the next clk edge.
- Single owner: req=0001, then we[0] with wdata0=8'h3C → grant=0001 one edge after req; q=8'h3C one edge after we. we[2]=1 with wdata2=8'hFF in the same cycle leaves q unchanged.
- Rotation: req=1111 held, each owner drops req after 2 cycles and re-raises it → grant sequence 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between each.
- Wrap and priority: ptr=3 (last owner 2), req=0101 → grant=0001. Then ptr=1, req=0101 → grant=0100.
- Timeout (macro on, MAX_HOLD=4): req[1] held high with req[3] pending → grant[1] for exactly 4 cycles, timeout pulse 1 cycle, then grant=1000 after the idle cycle. With the macro off, grant[1] persists for 100 cycles.
